// File: rtl/eth_img_pkg.sv
// Shared definitions for the UDP image frame receiver: FSM states,
// abort cause codes and the default frame-start word.
package eth_img_pkg;

    typedef enum logic [1:0] {
        WAIT_HEAD = 2'd0,
        WAIT_RES  = 2'd1,
        RECV      = 2'd2
    } state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_RES  = 3'd1;
    localparam logic [2:0] ERR_OVERFLOW = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] ERR_RESYNC   = 3'd4;

    localparam logic [31:0] DEF_HEAD_MAGIC = 32'hF05AA50F;

endpackage

// File: rtl/eth_img_word_fifo.sv
// Small synchronous word FIFO between the UDP side and the pixel serialiser.
// A push while full is accepted only when a pop happens in the same cycle;
// flush empties the FIFO immediately.
module eth_img_word_fifo
    import eth_img_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
)(
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_data    = r_mem[r_rptr[AW-1:0]];
    assign w_push_ok = i_push && (!o_full || i_pop);
    assign w_pop_ok  = i_pop && !o_empty;

    // Pointer update; flush and reset both return the FIFO to empty.
    always_ff @(posedge clk) begin
        if (!rstn || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/eth_img_frame_rx.sv
// UDP image frame receiver: parses magic + resolution header, buffers payload
// words in a small FIFO and serialises each word into two RGB565 pixels with
// line/frame markers, abort reporting and a completed-frame counter.
// Optional macro ETH_IMG_RESYNC_EN: a header word inside a frame aborts it and
// starts a new frame instead of being treated as pixel data.
module eth_img_frame_rx
    import eth_img_pkg::*;
#(
    parameter int                   UDP_WIDTH   = 32,
    parameter int                   PIX_WIDTH   = 16,
    parameter int                   MAX_H       = 1920,
    parameter int                   MAX_V       = 1080,
    parameter logic [UDP_WIDTH-1:0] HEAD_MAGIC  = DEF_HEAD_MAGIC,
    parameter int                   FIFO_DEPTH  = 4,
    parameter int                   TIMEOUT_CYC = 65535
)(
    input  logic                 eth_rx_clk,
    input  logic                 rstn,
    input  logic [UDP_WIDTH-1:0] udp_date_rcev,
    input  logic                 udp_date_en,
    output logic [PIX_WIDTH-1:0] img_data,
    output logic                 img_data_en,
    output logic                 img_data_vs,
    output logic                 img_data_sol,
    output logic                 img_data_eof,
    output logic [15:0]          img_h,
    output logic [15:0]          img_v,
    output logic [15:0]          frame_cnt,
    output logic                 frame_err,
    output logic [2:0]           err_code
);
    localparam int              WCNT_W    = $clog2(MAX_H * MAX_V / 2) + 1;
    localparam int              IDLE_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [15:0]     MAX_H16   = 16'(MAX_H);
    localparam logic [15:0]     MAX_V16   = 16'(MAX_V);

    state_t                 r_state, w_state_nxt;
    logic [15:0]            r_h, r_v, r_x, r_y, r_fcnt;
    logic [WCNT_W-1:0]      r_wtotal, r_wcnt;
    logic [IDLE_W-1:0]      r_idle;
    logic                   r_half, r_en, r_sol, r_eof, r_vs, r_err;
    logic [PIX_WIDTH-1:0]   r_lo, r_data;
    logic [2:0]             r_code;

    logic                   w_magic, w_res_ok, w_frame_open, w_pop, w_pix, w_last_pix;
    logic                   w_accept, w_push, w_abort, w_flush, w_done;
    logic [2:0]             w_code;
    logic [15:0]            w_res_h, w_res_v;
    logic [WCNT_W-1:0]      w_total;
    logic [UDP_WIDTH-1:0]   w_fifo_dout;
    logic                   w_full, w_empty;

    assign w_magic      = udp_date_en && (udp_date_rcev == HEAD_MAGIC);
    assign w_res_h      = udp_date_rcev[31:16];
    assign w_res_v      = udp_date_rcev[15:0];
    assign w_res_ok     = (w_res_h >= 16'd2) && (w_res_h <= MAX_H16) && !w_res_h[0]
                          && (w_res_v >= 16'd1) && (w_res_v <= MAX_V16);
    assign w_total      = WCNT_W'(w_res_h[15:1]) * WCNT_W'(w_res_v);
    assign w_frame_open = (r_wcnt != r_wtotal);
    assign w_pop        = (r_state == RECV) && !r_half && !w_empty;
    assign w_pix        = w_pop || r_half;
    assign w_last_pix   = (r_x == r_h - 16'd1) && (r_y == r_v - 16'd1);

    eth_img_word_fifo #(
        .WIDTH (UDP_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (eth_rx_clk),
        .rstn    (rstn),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (udp_date_rcev),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State register.
    always_ff @(posedge eth_rx_clk) begin
        if (!rstn) r_state <= WAIT_HEAD;
        else       r_state <= w_state_nxt;
    end

    // Header parsing, FIFO push decision, completion and abort causes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        w_abort     = 1'b0;
        w_flush     = 1'b0;
        w_done      = 1'b0;
        w_code      = ERR_NONE;
        case (r_state)
            WAIT_HEAD: begin
                if (w_magic) w_state_nxt = WAIT_RES;
            end
            WAIT_RES: begin
                if (udp_date_en && !w_magic) begin
                    if (w_res_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = RECV;
                    end else begin
                        w_abort     = 1'b1;
                        w_code      = ERR_BAD_RES;
                        w_state_nxt = WAIT_HEAD;
                    end
                end
            end
            RECV: begin
                if (r_eof) begin
                    w_done      = 1'b1;
                    w_flush     = 1'b1;
                    w_state_nxt = WAIT_HEAD;
`ifdef ETH_IMG_RESYNC_EN
                end else if (w_magic && w_frame_open) begin
                    w_abort     = 1'b1;
                    w_code      = ERR_RESYNC;
                    w_flush     = 1'b1;
                    w_state_nxt = WAIT_RES;
`endif
                end else if (udp_date_en && w_frame_open) begin
                    if (w_full && !w_pop) begin
                        w_abort     = 1'b1;
                        w_code      = ERR_OVERFLOW;
                        w_flush     = 1'b1;
                        w_state_nxt = WAIT_HEAD;
                    end else begin
                        w_push = 1'b1;
                    end
                end else if (!udp_date_en && (r_idle == IDLE_LAST)) begin
                    w_abort     = 1'b1;
                    w_code      = ERR_TIMEOUT;
                    w_flush     = 1'b1;
                    w_state_nxt = WAIT_HEAD;
                end
            end
            default: w_state_nxt = WAIT_HEAD;
        endcase
    end

    // Frame bookkeeping: resolution latch, word/idle counters, status pulses.
    always_ff @(posedge eth_rx_clk) begin
        if (!rstn) begin
            r_h      <= '0;
            r_v      <= '0;
            r_wtotal <= '0;
            r_wcnt   <= '0;
            r_idle   <= '0;
            r_vs     <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= ERR_NONE;
            r_fcnt   <= '0;
        end else begin
            r_vs  <= w_accept;
            r_err <= w_abort;
            if (w_abort) r_code <= w_code;
            if (w_done)  r_fcnt <= r_fcnt + 1'b1;
            if (w_accept) begin
                r_h      <= w_res_h;
                r_v      <= w_res_v;
                r_wtotal <= w_total;
                r_wcnt   <= '0;
            end else if (w_push) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (r_state != RECV || udp_date_en) r_idle <= '0;
            else                                r_idle <= r_idle + 1'b1;
        end
    end

    // Serialiser: high half on the pop cycle, low half on the next, with x/y tracking.
    always_ff @(posedge eth_rx_clk) begin
        if (!rstn) begin
            r_half <= 1'b0;
            r_lo   <= '0;
            r_data <= '0;
            r_en   <= 1'b0;
            r_sol  <= 1'b0;
            r_eof  <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
        end else if (w_flush || r_state != RECV) begin
            r_half <= 1'b0;
            r_en   <= 1'b0;
            r_sol  <= 1'b0;
            r_eof  <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
        end else begin
            r_en  <= w_pix;
            r_sol <= w_pix && (r_x == 16'd0);
            r_eof <= w_pix && w_last_pix;
            if (w_pop) begin
                r_data <= w_fifo_dout[UDP_WIDTH-1 -: PIX_WIDTH];
                r_lo   <= w_fifo_dout[PIX_WIDTH-1:0];
                r_half <= 1'b1;
            end else if (r_half) begin
                r_data <= r_lo;
                r_half <= 1'b0;
            end
            if (w_pix) begin
                if (r_x == r_h - 16'd1) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    assign img_data     = r_data;
    assign img_data_en  = r_en;
    assign img_data_vs  = r_vs;
    assign img_data_sol = r_sol;
    assign img_data_eof = r_eof;
    assign img_h        = r_h;
    assign img_v        = r_v;
    assign frame_cnt    = r_fcnt;
    assign frame_err    = r_err;
    assign err_code     = r_code;

endmodule
